// File: rtl/mont_exit_pkg.sv
// mont_exit_pkg: shared widths and FSM encoding for the RSA datapath
package mont_exit_pkg;
  localparam int DEF_W = 32;
  localparam int DEF_LW = 8;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/mont_exit_red_step.sv
// mont_red_step: one Montgomery halving step, t_out = (t_in + (t_in odd ? n : 0)) / 2; ports t_in[W:0], n[W-1:0] -> t_out[W:0]
module mont_red_step #(
  parameter int W = 32
) (
  input  logic [W:0]   t_in,
  input  logic [W-1:0] n,
  output logic [W:0]   t_out
);
  logic [W+1:0] s;
  always_comb begin
    s = {1'b0, t_in} + (t_in[0] ? {2'b0, n} : '0);
    t_out = (W+1)'(s >> 1);
  end
endmodule

// File: rtl/mont_exit.sv
// mont_exit: bit-serial md_out = num_in * 2^-len mod modulus; clk/rstn, start/len/num_in/modulus in, busy/done/err/md_out out
module mont_exit
  import mont_exit_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  num_in,
  input  logic [W-1:0]  modulus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  md_out
);
  state_t state, nxt;
  logic [W:0] t, t_nxt, diff;
  logic [W-1:0] n_r;
  logic [LW-1:0] cnt, len_s;
  mont_red_step #(.W(W)) u_step (.t_in(t), .n(n_r), .t_out(t_nxt));
  always_comb begin
    len_s = (len > LW'(W)) ? LW'(W) : len;
    diff = t - {1'b0, n_r};
    busy = state != IDLE;
    done = state == DONE;
    nxt = state;
    case (state)
      IDLE: nxt = start ? ((!modulus[0] || len_s == '0) ? FIX : RUN) : IDLE;
      RUN:  nxt = (cnt == LW'(1)) ? FIX : RUN;
      FIX:  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      t <= '0;
      n_r <= '0;
      cnt <= '0;
      err <= 1'b0;
      md_out <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        t <= {1'b0, num_in};
        n_r <= modulus;
        cnt <= len_s;
        err <= 1'b0;
      end
      if (state == RUN) begin
        t <= t_nxt;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        err <= ~n_r[0];
        // t < 2N after the loop, so the borrow bit alone decides t >= N
        md_out <= !n_r[0] ? '0 : (diff[W] ? t[W-1:0] : diff[W-1:0]);
      end
    end
  end
endmodule

// File: tb/tb_mont_exit.sv
// tb_mont_exit: directed and randomised checks of mont_exit against hand values and a modular-inverse model
module tb_mont_exit;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [7:0] len = '0;
  logic [31:0] num_in = '0, modulus = '0;
  logic busy, done, err;
  logic [31:0] md_out;
  int n_chk = 0, n_pass = 0, cyc = 0, cyc0 = 0;
  mont_exit dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .num_in(num_in),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .md_out(md_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] ref_red(input logic [63:0] n, input logic [63:0] x, input int l);
    logic [63:0] h, r;
    h = (n + 1) >> 1;
    r = 1 % n;
    for (int i = 0; i < l; i++) r = (r * h) % n;
    return 32'((x % n) * r % n);
  endfunction
  task automatic start_op(input logic [31:0] n, input logic [7:0] l, input logic [31:0] x);
    modulus = n;
    len = l;
    num_in = x;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc0 = cyc;
  endtask
  task automatic finish_op(input string tag, input logic [31:0] em, input logic ee, input int el);
    while (!done && cyc - cyc0 < 200) begin
      @(posedge clk);
      #1;
    end
    chk({tag, " latency"}, 64'(cyc - cyc0 + 1), 64'(el));
    chk({tag, " md_out"}, 64'(md_out), 64'(em));
    chk({tag, " err"}, 64'(err), 64'(ee));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, " done pulse"}, 64'(done), 64'd0);
    chk({tag, " done-cycle start ignored"}, 64'(busy), 64'd0);
    chk({tag, " held"}, {31'd0, err, md_out}, {31'd0, ee, em});
  endtask
  initial begin
    logic [63:0] n, x;
    int l;
    bit seen;
    #12;
    chk("reset outs", {busy, done, err, md_out}, 35'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    start_op(32'd13, 8'd4, 32'd1);
    chk("busy after start", 64'(busy), 64'd1);
    finish_op("n13 x1", 32'd9, 1'b0, 6);
    start_op(32'd13, 8'd4, 32'd3);
    finish_op("n13 x3", 32'd1, 1'b0, 6);
    start_op(32'd13, 8'd4, 32'd0);
    finish_op("n13 x0", 32'd0, 1'b0, 6);
    start_op(32'd13, 8'd0, 32'd20);
    finish_op("len0", 32'd7, 1'b0, 2);
    start_op(32'hFFFF_FFFF, 8'd40, 32'hFFFF_FFFE);
    finish_op("len sat", 32'hFFFF_FFFE, 1'b0, 34);
    start_op(32'd12, 8'd4, 32'd5);
    finish_op("even n", 32'd0, 1'b1, 2);
    start_op(32'd0, 8'd4, 32'd5);
    finish_op("zero n", 32'd0, 1'b1, 2);
    start_op(32'd13, 8'd4, 32'd1);
    finish_op("err clear", 32'd9, 1'b0, 6);
    start_op(32'd13, 8'd4, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    modulus = 32'd12;
    num_in = 32'd99;
    len = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_op("midrun change", 32'd9, 1'b0, 6);
    start_op(32'd13, 8'd4, 32'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("async reset outs", {busy, done, err, md_out}, 35'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("no done after reset", 64'(seen), 64'd0);
    start_op(32'd13, 8'd4, 32'd3);
    finish_op("after reset", 32'd1, 1'b0, 6);
    for (int k = 0; k < 20; k++) begin
      n = {32'd0, $urandom | 32'd1};
      x = {32'd0, $urandom} % (2 * n);
      l = $urandom_range(0, 40);
      start_op(32'(n), 8'(l), 32'(x));
      finish_op($sformatf("rand%0d", k), ref_red(n, x, l > 32 ? 32 : l), 1'b0, (l > 32 ? 32 : l) + 2);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
